// File: rtl/relu_arbiter.sv
// Round-robin arbiter feeding a one-deep ReLU result register with back-to-back throughput.
// Optional saturating clip counter (clip_cnt/clip_clr) is built when RELU_ARB_CLIP_CNT_EN is defined.
module relu_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef RELU_ARB_CLIP_CNT_EN
    input  logic                       clip_clr,
    output logic [15:0]                clip_cnt,
`endif
    input  logic                       en,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DW-1:0]        req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       res_valid,
    output logic [DW-1:0]              res_data,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    input  logic                       res_ready
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned SW = IW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   nxt_ptr;
    logic [SW-1:0]   idx;
    logic            found;
    logic            grant;
    logic [DW-1:0]   win_data;

    // Rotating priority search starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + SW'(k);
            if (idx >= SW'(N_REQ)) begin
                idx = idx - SW'(N_REQ);
            end
            if (!found && req_valid[idx[IW-1:0]]) begin
                winner = idx[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    // Reset gates the grant so nothing is accepted while the slot is being cleared.
    always_comb begin
        grant     = rst_n & en & found & ((state == IDLE) | res_ready);
        win_data  = req_data[32'(winner) * DW +: DW];
        nxt_ptr   = (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign res_valid = (state == HOLD);

    // Result slot: load on grant, otherwise hold; empty when drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            res_data <= '0;
            res_id   <= '0;
            ptr      <= '0;
        end else if (grant) begin
            state    <= HOLD;
            res_data <= win_data[DW-1] ? '0 : win_data;
            res_id   <= winner;
            ptr      <= nxt_ptr;
        end else if ((state == HOLD) && res_ready) begin
            state    <= IDLE;
        end
    end

`ifdef RELU_ARB_CLIP_CNT_EN
    // Counts granted negative inputs; clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt <= '0;
        end else if (clip_clr) begin
            clip_cnt <= '0;
        end else if (grant && win_data[DW-1] && (clip_cnt != 16'hFFFF)) begin
            clip_cnt <= clip_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_relu_arbiter.sv
// Scoreboard bench for relu_arbiter: stimulus pushes expected results, a monitor pops on each transfer.
// Clip counter checks are compiled in when RELU_ARB_CLIP_CNT_EN is defined.
module tb_relu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic        res_ready;
    logic        clip_clr;
    logic [15:0] clip_cnt;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    relu_arbiter #(.N_REQ(4), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef RELU_ARB_CLIP_CNT_EN
        .clip_clr  (clip_clr),
        .clip_cnt  (clip_cnt),
`endif
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

`ifndef RELU_ARB_CLIP_CNT_EN
    assign clip_cnt = 16'h0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string name, input logic [1:0] id, input logic [7:0] d);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        @(negedge clk);
        chk(name, 32'(req_ready), 32'(oh));
        q.push_back(exp_t'({id, d}));
        cyc();
    endtask

    task automatic set_lane(input logic [1:0] id, input logic [7:0] d);
        req_data[32'(id) * 8 +: 8] = d;
    endtask

    // Monitor: every accepted result is compared against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid && res_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got id=%0d data=%0h, none expected", res_id, res_data);
            end else begin
                e = q.pop_front();
                chk("res_data", 32'(res_data), 32'(e.data));
                chk("res_id", 32'(res_id), 32'(e.id));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] fair_id [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] fair_d  [5]  = '{8'h10, 8'h00, 8'h7F, 8'h00, 8'h10};
        logic [1:0] clip_id [4]  = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] clip_in [4]  = '{8'h80, 8'hFF, 8'h00, 8'h7F};
        logic [7:0] clip_out[4]  = '{8'h00, 8'h00, 8'h00, 8'h7F};

        rst_n     = 1'b0;
        en        = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'h0;
        res_ready = 1'b1;
        clip_clr  = 1'b0;

        // Reset values, with requests present to show nothing is accepted.
        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef RELU_ARB_CLIP_CNT_EN
        chk("rst_clip_cnt", 32'(clip_cnt), 32'd0);
`endif
        req_valid = 4'h0;
        cyc();
        rst_n = 1'b1;

        // Single request from requester 2.
        req_valid = 4'b0100;
        set_lane(2'd2, 8'h25);
        expect_grant("single_grant", 2'd2, 8'h25);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("single_latency_valid", 32'(res_valid), 32'd1);
        cyc();

        // Fresh reset so the fairness run starts from pointer 0.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req_data  = {8'h00, 8'h7F, 8'h85, 8'h10};
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            expect_grant("fair_grant", fair_id[i], fair_d[i]);
        end
        req_valid = 4'h0;
`ifdef RELU_ARB_CLIP_CNT_EN
        @(negedge clk);
        chk("fair_clip_cnt", 32'(clip_cnt), 32'd1);
        clip_clr = 1'b1;
        cyc();
        clip_clr = 1'b0;
        @(negedge clk);
        chk("clip_clr_first", 32'(clip_cnt), 32'd0);
`endif
        cyc();

        // Clipping boundaries, one requester at a time (pointer is 1 here).
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001 << clip_id[i];
            set_lane(clip_id[i], clip_in[i]);
            expect_grant("clip_grant", clip_id[i], clip_out[i]);
        end
        req_valid = 4'h0;
        @(negedge clk);
`ifdef RELU_ARB_CLIP_CNT_EN
        chk("clip_cnt_two", 32'(clip_cnt), 32'd2);
        cyc();
        clip_clr = 1'b1;
        cyc();
        clip_clr = 1'b0;
        @(negedge clk);
        chk("clip_clr_pulse", 32'(clip_cnt), 32'd0);
`endif
        cyc();

        // Backpressure: hold result for 5 cycles, then reload on the draining edge.
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'hF;
        res_ready = 1'b0;
        expect_grant("bp_first", 2'd1, 8'h22);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_res_data", 32'(res_data), 32'h22);
            chk("bp_res_id", 32'(res_id), 32'd1);
            cyc();
        end
        res_ready = 1'b1;
        expect_grant("bp_reload", 2'd2, 8'h33);
        req_valid = 4'h0;
        cyc();

        // Enable low: held result drains, no grant, resume at stored pointer.
        req_valid = 4'b0100;
        res_ready = 1'b0;
        expect_grant("en_first", 2'd2, 8'h33);
        en        = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        chk("en0_hold_ready", 32'(req_ready), 32'd0);
        chk("en0_hold_valid", 32'(res_valid), 32'd1);
        cyc();
        res_ready = 1'b1;
        @(negedge clk);
        chk("en0_drain_ready", 32'(req_ready), 32'd0);
        cyc();
        @(negedge clk);
        chk("en0_idle_valid", 32'(res_valid), 32'd0);
        chk("en0_idle_ready", 32'(req_ready), 32'd0);
        cyc();
        en = 1'b1;
        expect_grant("en_resume", 2'd3, 8'h44);

        // Asynchronous reset while a result is held.
        res_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(res_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(res_valid), 32'd0);
        chk("discarded_pending", 32'(q.size()), 32'd1);
        q.delete();
        cyc();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        req_valid = 4'hF;
        expect_grant("post_rst_grant", 2'd0, 8'h11);
        req_valid = 4'h0;
        repeat (3) cyc();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
